chunked_serial_adder: RTL and testbench

Multi-cycle, parametrised successor to the ALU's combinational 64-bit adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with the carry rippling between chunks through a register. The result comes with carry-out, signed-overflow and zero flags. It sits beside the ALU for area-constrained builds and uses a start/done handshake in place of a same-cycle result.

---
 rtl/chunked_serial_adder.sv | 150 +++++++++++++++
 tb/tb_chunked_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_serial_adder
// Description : Multi-cycle WIDTH-bit adder/subtractor. Processes CHUNK bits
//               per clock, rippling the carry between chunks in a register.
//               Produces sum plus carry-out, signed-overflow and zero flags
//               behind a start/done handshake.
// Ports       : clk, reset (sync, active-high)
//               start, sub, a, b, cin  - request and operands, sampled with
//                                        start in IDLE or DONE
//               busy                   - high while chunks are being processed
//               done                   - one-cycle result-valid pulse
//               sum, cout, overflow,
//               zero                   - result and flags, updated only on the
//                                        edge entering DONE
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_serial_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int              C_N    = WIDTH / CHUNK;
    localparam int              C_IW   = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_IW-1:0] C_LAST = C_IW'(C_N - 1);
    localparam logic [C_IW-1:0] C_ONE  = C_IW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [C_IW-1:0]  r_idx;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK:0]   w_chunk_res;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_carry_msb;

    // ------------------------------------------------------------------------
    // Chunk datapath. Operands are shifted right each RUN cycle so the active
    // chunk always sits in the low CHUNK bits; the accumulator shifts in from
    // the top, so after N cycles chunk idx lands at bits [idx*CHUNK +: CHUNK].
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last      = (r_state == S_RUN) && (r_idx == C_LAST);
        w_chunk_res = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};
        w_acc_next  = (r_acc >> CHUNK)
                    | (WIDTH'(w_chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
        // On the last chunk the top bit of the chunk is operand bit WIDTH-1;
        // sum = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
        w_carry_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk_res[CHUNK-1];
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, accumulator and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1; the +1 rides in on the carry.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_acc   <= w_acc_next;
            r_carry <= w_chunk_res[CHUNK];
            r_idx   <= r_idx + C_ONE;
            if (w_last) begin
                sum      <= w_acc_next;
                cout     <= w_chunk_res[CHUNK];
                overflow <= w_carry_msb ^ w_chunk_res[CHUNK];
                zero     <= (w_acc_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_serial_adder
// Description : Self-checking bench for chunked_serial_adder. A CHUNK=8
//               instance takes directed vectors; CHUNK=1/16/64 instances run a
//               shared random sweep against a 65-bit reference sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_serial_adder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    logic        start2;
    logic        sub2;
    logic [63:0] a2;
    logic [63:0] b2;
    logic        cin2;
    logic        s_busy [3];
    logic        s_done [3];
    logic [63:0] s_sum  [3];
    logic        s_cout [3];
    logic        s_ovf  [3];
    logic        s_zero [3];

    int n_pass;
    int n_tot;

    chunked_serial_adder #(.WIDTH(64), .CHUNK(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        chunked_serial_adder #(
            .WIDTH (64),
            .CHUNK ((gi == 0) ? 1 : ((gi == 1) ? 16 : 64))
        ) u_sw (
            .clk      (clk),
            .reset    (reset),
            .start    (start2),
            .sub      (sub2),
            .a        (a2),
            .b        (b2),
            .cin      (cin2),
            .busy     (s_busy[gi]),
            .done     (s_done[gi]),
            .sum      (s_sum[gi]),
            .cout     (s_cout[gi]),
            .overflow (s_ovf[gi]),
            .zero     (s_zero[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int chunk_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 16 : 64);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the CHUNK=8 instance; lat counts cycles from the one
    // after the start edge (=1) to the done cycle.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tbv,
                          input logic ts, input logic tc,
                          output int lat, output int nbusy);
        a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_tot++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_tot++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_tot++; if (sum !== 64'h0) $display("FAIL reset_sum got %h want 0", sum); else n_pass++;
        n_tot++; if ({cout, overflow, zero} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {cout, overflow, zero}); else n_pass++;
    endtask

    task automatic test_add_carry;
        int lat, nb;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, nb);
        n_tot++; if (lat !== 9) $display("FAIL add_latency got %0d want 9", lat); else n_pass++;
        n_tot++; if (nb !== 8) $display("FAIL add_busy_cycles got %0d want 8", nb); else n_pass++;
        n_tot++; if (sum !== 64'h0) $display("FAIL add_sum got %h want 0", sum); else n_pass++;
        n_tot++; if ({cout, zero, overflow} !== 3'b110)
            $display("FAIL add_flags(c,z,v) got %b want 110", {cout, zero, overflow}); else n_pass++;
    endtask

    task automatic test_sub;
        int lat, nb;
        run_op(64'd5, 64'd7, 1'b1, 1'b0, lat, nb);
        n_tot++; if (sum !== 64'hFFFF_FFFF_FFFF_FFFE)
            $display("FAIL sub_sum got %h want fffffffffffffffe", sum); else n_pass++;
        n_tot++; if ({cout, overflow, zero} !== 3'b000)
            $display("FAIL sub_flags(c,v,z) got %b want 000", {cout, overflow, zero}); else n_pass++;
        // 10 - 3 - 1 = 6, no borrow
        run_op(64'd10, 64'd3, 1'b1, 1'b1, lat, nb);
        n_tot++; if ({cout, sum} !== {1'b1, 64'd6})
            $display("FAIL sub_cin got c=%b s=%h want c=1 s=6", cout, sum); else n_pass++;
        // add with carry-in: 1 + 1 + 1 = 3
        run_op(64'd1, 64'd1, 1'b0, 1'b1, lat, nb);
        n_tot++; if ({cout, sum} !== {1'b0, 64'd3})
            $display("FAIL add_cin got c=%b s=%h want c=0 s=3", cout, sum); else n_pass++;
    endtask

    task automatic test_overflow;
        int lat, nb;
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, nb);
        n_tot++; if (sum !== 64'h8000_0000_0000_0000)
            $display("FAIL ovf_add_sum got %h want 8000000000000000", sum); else n_pass++;
        n_tot++; if ({overflow, cout} !== 2'b10)
            $display("FAIL ovf_add_flags(v,c) got %b want 10", {overflow, cout}); else n_pass++;
        // most-negative minus one wraps to most-positive
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, lat, nb);
        n_tot++; if ({overflow, cout, sum} !== {2'b11, 64'h7FFF_FFFF_FFFF_FFFF})
            $display("FAIL ovf_sub got v=%b c=%b s=%h want v=1 c=1 s=7fffffffffffffff",
                     overflow, cout, sum); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cnt, cnt2, hold_err;
        tick();
        a = 64'd10; b = 64'd20; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; cnt = 1;
        tick(); cnt = 2;
        a = 64'd1; b = 64'd2; start = 1'b1;
        tick(); cnt = 3;
        start = 1'b0;
        while (cnt < 8) begin tick(); cnt++; end
        a = 64'd3; b = 64'd4; start = 1'b1;
        tick();
        n_tot++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", done); else n_pass++;
        n_tot++; if (sum !== 64'd30) $display("FAIL b2b_first_sum got %0d want 30", sum); else n_pass++;
        tick();
        start = 1'b0;
        cnt2 = 1; hold_err = 0;
        while (!done && cnt2 < 40) begin
            if (sum !== 64'd30 || busy !== 1'b1) hold_err++;
            tick();
            cnt2++;
        end
        n_tot++; if (hold_err !== 0) $display("FAIL b2b_hold got %0d bad cycles want 0", hold_err); else n_pass++;
        n_tot++; if (cnt2 !== 9) $display("FAIL b2b_latency got %0d want 9", cnt2); else n_pass++;
        n_tot++; if (sum !== 64'd7) $display("FAIL b2b_second_sum got %0d want 7", sum); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int lat, nb, pulses;
        tick();
        a = 64'hFFFF_0000_FFFF_0000; b = 64'h1234; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tot++; if ({busy, done} !== 2'b00) $display("FAIL midrst_ctrl got %b want 00", {busy, done}); else n_pass++;
        n_tot++; if ({sum, cout, overflow, zero} !== 67'h0)
            $display("FAIL midrst_outputs got s=%h c=%b v=%b z=%b want all 0",
                     sum, cout, overflow, zero); else n_pass++;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        n_tot++; if (pulses !== 0) $display("FAIL midrst_activity got %0d want 0", pulses); else n_pass++;
        run_op(64'd2, 64'd2, 1'b0, 1'b0, lat, nb);
        n_tot++; if (sum !== 64'd4) $display("FAIL midrst_after_sum got %0d want 4", sum); else n_pass++;
        n_tot++; if (lat !== 9) $display("FAIL midrst_after_latency got %0d want 9", lat); else n_pass++;
    endtask

    task automatic test_reset_and_start;
        tick();
        a = 64'd9; b = 64'd9; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        n_tot++; if (busy !== 1'b0) $display("FAIL rst_start_busy got %b want 0", busy); else n_pass++;
        tick();
        n_tot++; if ({busy, done} !== 2'b00) $display("FAIL rst_start_idle got %b want 00", {busy, done}); else n_pass++;
    endtask

    task automatic test_sweep;
        logic [64:0] ex;
        logic [63:0] bb;
        logic        eo;
        int          cnt;
        bit          seen [3];
        for (int op = 0; op < 1000; op++) begin
            a2   = {$urandom, $urandom};
            b2   = (op % 10 == 0) ? a2 : {$urandom, $urandom};
            sub2 = 1'($urandom_range(0, 1));
            cin2 = 1'($urandom_range(0, 1));
            bb = b2 ^ {64{sub2}};
            ex = {1'b0, a2} + {1'b0, bb} + 65'(cin2 ^ sub2);
            eo = (a2[63] == bb[63]) && (ex[63] != a2[63]);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            cnt = 1;
            for (int k = 0; k < 3; k++) seen[k] = 1'b0;
            while (!(seen[0] && seen[1] && seen[2]) && cnt <= 70) begin
                for (int k = 0; k < 3; k++) begin
                    if (!seen[k] && s_done[k]) begin
                        seen[k] = 1'b1;
                        n_tot++;
                        if ({s_cout[k], s_ovf[k], s_sum[k]} !== {ex[64], eo, ex[63:0]})
                            $display("FAIL sweep_c%0d_result op=%0d got c=%b v=%b s=%h want c=%b v=%b s=%h",
                                     chunk_of(k), op, s_cout[k], s_ovf[k], s_sum[k], ex[64], eo, ex[63:0]);
                        else n_pass++;
                        n_tot++;
                        if (cnt !== 64 / chunk_of(k) + 1)
                            $display("FAIL sweep_c%0d_latency op=%0d got %0d want %0d",
                                     chunk_of(k), op, cnt, 64 / chunk_of(k) + 1);
                        else n_pass++;
                    end
                end
                tick();
                cnt++;
            end
            for (int k = 0; k < 3; k++) begin
                n_tot++;
                if (seen[k] !== 1'b1)
                    $display("FAIL sweep_c%0d_timeout op=%0d got no done want done", chunk_of(k), op);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        test_reset();
        test_add_carry();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_and_start();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
